// File: rtl/exe_stage.sv
// Execute stage: one-cycle ALU and multiplier, 32-cycle restoring divider,
// forwarding info back to decode and the data-SRAM request for loads/stores.
module exe_stage #(
    parameter int DS2ES_LEN = 155,
    parameter int ES2MS_LEN = 71
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 ds2es_valid,
    output logic                 es_allowin,
    input  logic [DS2ES_LEN-1:0] ds2es_bus,
    input  logic                 ms_allowin,
    output logic                 es2ms_valid,
    output logic [ES2MS_LEN-1:0] es2ms_bus,
    output logic [38:0]          es_rf_zip,
    output logic                 data_sram_en,
    output logic [3:0]           data_sram_we,
    output logic [31:0]          data_sram_addr,
    output logic [31:0]          data_sram_wdata
);

    typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

    logic                 es_valid_reg;
    logic [DS2ES_LEN-1:0] ds2es_bus_reg;

    logic [18:0] alu_op;
    logic        res_from_mem;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        mem_we;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rkd_value;
    logic [31:0] pc;

    assign {alu_op, res_from_mem, src1, src2, mem_we, rf_we, rf_waddr, rkd_value, pc} = ds2es_bus_reg;

    logic is_div;
    logic es_ready_go;
    logic mem_go;
    div_state_t div_state_reg;

    assign is_div      = |alu_op[18:15];
    assign es_ready_go = ~is_div | (div_state_reg == DIV_DONE);
    assign es_allowin  = ~es_valid_reg | (es_ready_go & ms_allowin);
    assign es2ms_valid = es_valid_reg & es_ready_go;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            es_valid_reg  <= 1'b0;
            ds2es_bus_reg <= '0;
        end else begin
            if (es_allowin)
                es_valid_reg <= ds2es_valid;
            if (ds2es_valid & es_allowin)
                ds2es_bus_reg <= ds2es_bus;
        end
    end

    // One 33x33 signed product serves mul, mulh and mulhu; bit 32 is the sign extension.
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [65:0] mul_prod;

    assign mul_a    = {alu_op[13] & src1[31], src1};
    assign mul_b    = {alu_op[13] & src2[31], src2};
    assign mul_prod = 66'(mul_a) * 66'(mul_b);

    // Divider datapath: dvd_reg shifts the dividend out and the quotient in.
    logic [4:0]  count_reg;
    logic [31:0] dvd_reg;
    logic [31:0] dvs_reg;
    logic [31:0] rem_reg;
    logic        q_neg_reg;
    logic        r_neg_reg;

    logic        div_signed;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic        q_bit;
    logic [31:0] quot_final;
    logic [31:0] rem_final;

    assign div_signed = alu_op[15] | alu_op[17];
    assign abs1       = (div_signed & src1[31]) ? (~src1 + 32'd1) : src1;
    assign abs2       = (div_signed & src2[31]) ? (~src2 + 32'd1) : src2;
    assign rem_shift  = {rem_reg, dvd_reg[31]};
    assign trial      = {1'b0, rem_shift} - {2'b00, dvs_reg};
    assign q_bit      = ~trial[33];
    assign quot_final = q_neg_reg ? (~dvd_reg + 32'd1) : dvd_reg;
    assign rem_final  = r_neg_reg ? (~rem_reg + 32'd1) : rem_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_state_reg <= DIV_IDLE;
            count_reg     <= 5'd0;
            dvd_reg       <= 32'd0;
            dvs_reg       <= 32'd0;
            rem_reg       <= 32'd0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
        end else begin
            case (div_state_reg)
                DIV_IDLE: begin
                    if (es_valid_reg & is_div) begin
                        dvd_reg       <= abs1;
                        dvs_reg       <= abs2;
                        rem_reg       <= 32'd0;
                        // A zero divisor keeps the all-ones quotient unsigned-looking.
                        q_neg_reg     <= div_signed & (src1[31] ^ src2[31]) & (|src2);
                        r_neg_reg     <= div_signed & src1[31];
                        count_reg     <= 5'd0;
                        div_state_reg <= DIV_CALC;
                    end
                end
                DIV_CALC: begin
                    rem_reg   <= q_bit ? trial[31:0] : rem_shift[31:0];
                    dvd_reg   <= {dvd_reg[30:0], q_bit};
                    count_reg <= count_reg + 5'd1;
                    if (count_reg == 5'd31)
                        div_state_reg <= DIV_DONE;
                end
                DIV_DONE: begin
                    if (ms_allowin)
                        div_state_reg <= DIV_IDLE;
                end
                default: div_state_reg <= DIV_IDLE;
            endcase
        end
    end

    logic [31:0] alu_result;

    always_comb begin
        alu_result = 32'd0;
        if (alu_op[0])  alu_result = src1 + src2;
        if (alu_op[1])  alu_result = src1 - src2;
        if (alu_op[2])  alu_result = {31'd0, $signed(src1) < $signed(src2)};
        if (alu_op[3])  alu_result = {31'd0, src1 < src2};
        if (alu_op[4])  alu_result = src1 & src2;
        if (alu_op[5])  alu_result = ~(src1 | src2);
        if (alu_op[6])  alu_result = src1 | src2;
        if (alu_op[7])  alu_result = src1 ^ src2;
        if (alu_op[8])  alu_result = src1 << src2[4:0];
        if (alu_op[9])  alu_result = src1 >> src2[4:0];
        if (alu_op[10]) alu_result = $signed(src1) >>> src2[4:0];
        if (alu_op[11]) alu_result = src2;
        if (alu_op[12]) alu_result = mul_prod[31:0];
        if (alu_op[13] | alu_op[14]) alu_result = mul_prod[63:32];
        if (alu_op[15] | alu_op[16]) alu_result = quot_final;
        if (alu_op[17] | alu_op[18]) alu_result = rem_final;
    end

    logic [31:0] result_out;
    logic        not_ready;

    assign result_out = es_valid_reg ? alu_result : 32'd0;
    assign not_ready  = es_valid_reg & (res_from_mem | (is_div & (div_state_reg != DIV_DONE)));

    assign es2ms_bus = es_valid_reg ? {res_from_mem, rf_we, rf_waddr, alu_result, pc} : '0;
    assign es_rf_zip = {not_ready, es_valid_reg & rf_we, es_valid_reg ? rf_waddr : 5'd0, result_out};

    // The request goes out only on the cycle the instruction actually moves on.
    assign mem_go          = es_valid_reg & ms_allowin;
    assign data_sram_en    = mem_go & (res_from_mem | mem_we);
    assign data_sram_addr  = result_out;
    assign data_sram_wdata = es_valid_reg ? rkd_value : 32'd0;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_we
            assign data_sram_we[gi] = mem_go & mem_we;
        end
    endgenerate

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed corner cases followed by random
// operations compared against an arithmetic reference model.
module tb_exe_stage;

    logic         clk;
    logic         resetn;
    logic         ds2es_valid;
    logic         es_allowin;
    logic [154:0] ds2es_bus;
    logic         ms_allowin;
    logic         es2ms_valid;
    logic [70:0]  es2ms_bus;
    logic [38:0]  es_rf_zip;
    logic         data_sram_en;
    logic [3:0]   data_sram_we;
    logic [31:0]  data_sram_addr;
    logic [31:0]  data_sram_wdata;

    int n_cmp = 0;
    int n_err = 0;

    exe_stage dut (
        .clk            (clk),
        .resetn         (resetn),
        .ds2es_valid    (ds2es_valid),
        .es_allowin     (es_allowin),
        .ds2es_bus      (ds2es_bus),
        .ms_allowin     (ms_allowin),
        .es2ms_valid    (es2ms_valid),
        .es2ms_bus      (es2ms_bus),
        .es_rf_zip      (es_rf_zip),
        .data_sram_en   (data_sram_en),
        .data_sram_we   (data_sram_we),
        .data_sram_addr (data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [70:0] obs, input logic [70:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model straight from the instruction definitions.
    function automatic logic [31:0] model(input int op, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      sr;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        up = {32'd0, a} * {32'd0, b};
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return (sa < sb) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return a << b[4:0];
            9:  return a >> b[4:0];
            10: begin sr = sa >>> b[4:0]; return sr[31:0]; end
            11: return b;
            12: return up[31:0];
            13: begin sr = sa * sb; return sr[63:32]; end
            14: return up[63:32];
            15: begin if (b == 0) return 32'hFFFFFFFF; sr = sa / sb; return sr[31:0]; end
            16: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            17: begin if (b == 0) return a; sr = sa % sb; return sr[31:0]; end
            18: begin if (b == 0) return a; return a % b; end
            default: return 32'd0;
        endcase
    endfunction

    // Called on a falling edge; the instruction is in execute at the next falling edge.
    task automatic issue(input int op, input logic [31:0] a, input logic [31:0] b,
                         input logic rfm, input logic mw, input logic rfwe,
                         input logic [4:0] wa, input logic [31:0] rkd, input logic [31:0] pc);
        logic [18:0] opv;
        opv = 19'd1 << op;
        ds2es_bus   = {opv, rfm, a, b, mw, rfwe, wa, rkd, pc};
        ds2es_valid = 1'b1;
        @(negedge clk);
        ds2es_valid = 1'b0;
    endtask

    // Counts cycles until es2ms_valid; also counts cycles that violated the stall contract.
    task automatic wait_done(output int lat, output int viol);
        lat  = 0;
        viol = 0;
        while (!es2ms_valid && lat < 100) begin
            if (es_allowin !== 1'b0 || es_rf_zip[38] !== 1'b1) viol++;
            @(negedge clk);
            lat++;
        end
    endtask

    function automatic logic [70:0] exp_bus(input logic rfm, input logic rfwe, input logic [4:0] wa,
                                            input logic [31:0] r, input logic [31:0] pc);
        return {rfm, rfwe, wa, r, pc};
    endfunction

    initial begin : tb_main
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          viol;
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pc;
        logic [4:0]  wa;
        logic        rfwe;

        resetn      = 1'b0;
        ds2es_valid = 1'b0;
        ms_allowin  = 1'b1;
        ds2es_bus   = '0;
        repeat (2) @(negedge clk);

        check("reset_allowin", 71'(es_allowin), 71'd1);
        check("reset_valid",   71'(es2ms_valid), 71'd0);
        check("reset_bus",     es2ms_bus, 71'd0);
        check("reset_zip",     71'(es_rf_zip), 71'd0);
        check("reset_sram",    71'({data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}), 71'd0);
        resetn = 1'b1;
        @(negedge clk);

        // add.w overflow wraps, completes in one cycle
        issue(0, 32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b1, 5'd3, 32'd0, 32'h1C000000);
        wait_done(lat, viol);
        check("add_latency", 71'(lat), 71'd0);
        check("add_bus", es2ms_bus, exp_bus(1'b0, 1'b1, 5'd3, 32'h80000000, 32'h1C000000));
        check("add_zip", 71'(es_rf_zip), 71'({1'b0, 1'b1, 5'd3, 32'h80000000}));
        @(negedge clk);

        // multiply family on all-ones operands
        issue(13, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'h100);
        wait_done(lat, viol);
        check("mulh_w", 71'(es2ms_bus[63:32]), 71'h00000000);
        @(negedge clk);
        issue(14, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'h104);
        wait_done(lat, viol);
        check("mulh_wu", 71'(es2ms_bus[63:32]), 71'hFFFFFFFE);
        @(negedge clk);
        issue(12, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd4, 32'd0, 32'h108);
        wait_done(lat, viol);
        check("mul_w", 71'(es2ms_bus[63:32]), 71'h00000001);
        @(negedge clk);

        // signed divide and modulo with latency and stall behaviour
        issue(15, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h200);
        wait_done(lat, viol);
        check("div_w_latency", 71'(lat), 71'd33);
        check("div_w_stall", 71'(viol), 71'd0);
        check("div_w_result", 71'(es2ms_bus[63:32]), 71'hFFFFFFFD);
        check("div_w_zip_ready", 71'(es_rf_zip[38]), 71'd0);
        @(negedge clk);
        issue(17, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0, 1'b1, 5'd5, 32'd0, 32'h204);
        wait_done(lat, viol);
        check("mod_w_latency", 71'(lat), 71'd33);
        check("mod_w_result", 71'(es2ms_bus[63:32]), 71'hFFFFFFFF);
        @(negedge clk);

        // divide-by-zero and signed overflow corners
        issue(16, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6, 32'd0, 32'h300);
        wait_done(lat, viol);
        check("div_wu_by0", 71'(es2ms_bus[63:32]), 71'hFFFFFFFF);
        @(negedge clk);
        issue(18, 32'd5, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6, 32'd0, 32'h304);
        wait_done(lat, viol);
        check("mod_wu_by0", 71'(es2ms_bus[63:32]), 71'd5);
        @(negedge clk);
        issue(15, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1, 5'd6, 32'd0, 32'h308);
        wait_done(lat, viol);
        check("div_w_ovf", 71'(es2ms_bus[63:32]), 71'h80000000);
        @(negedge clk);

        // st.w held by a 3-cycle memory-stage stall
        ms_allowin = 1'b0;
        issue(0, 32'h18, 32'h4, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEADBEEF, 32'h400);
        for (int k = 0; k < 3; k++) begin
            check("st_stall_en", 71'({data_sram_en, data_sram_we}), 71'd0);
            @(negedge clk);
        end
        ms_allowin = 1'b1;
        #1;
        check("st_en",    71'(data_sram_en), 71'd1);
        check("st_we",    71'(data_sram_we), 71'hF);
        check("st_addr",  71'(data_sram_addr), 71'h1C);
        check("st_wdata", 71'(data_sram_wdata), 71'hDEADBEEF);
        @(negedge clk);
        check("st_single", 71'(data_sram_en), 71'd0);

        // reset in the middle of a divide
        issue(15, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b1, 5'd7, 32'd0, 32'h500);
        repeat (10) @(negedge clk);
        resetn = 1'b0;
        #1;
        check("rst_mid_valid", 71'(es2ms_valid), 71'd0);
        check("rst_mid_allow", 71'(es_allowin), 71'd1);
        check("rst_mid_zip",   71'(es_rf_zip), 71'd0);
        #1;
        resetn = 1'b1;
        @(negedge clk);
        issue(0, 32'd3, 32'd4, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0, 32'h600);
        wait_done(lat, viol);
        check("post_rst_lat", 71'(lat), 71'd0);
        check("post_rst_add", es2ms_bus, exp_bus(1'b0, 1'b1, 5'd8, 32'd7, 32'h600));
        @(negedge clk);
        issue(16, 32'd100, 32'd9, 1'b0, 1'b0, 1'b1, 5'd8, 32'd0, 32'h604);
        wait_done(lat, viol);
        check("post_rst_div_lat", 71'(lat), 71'd33);
        check("post_rst_div", 71'(es2ms_bus[63:32]), 71'd11);
        @(negedge clk);

        // random operations against the reference model
        for (int i = 0; i < 40; i++) begin
            op   = $urandom_range(0, 18);
            a    = $urandom;
            b    = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            pc   = $urandom;
            wa   = 5'($urandom);
            rfwe = 1'($urandom);
            issue(op, a, b, 1'b0, 1'b0, rfwe, wa, 32'd0, pc);
            wait_done(lat, viol);
            check($sformatf("rnd%0d_op%0d_lat", i, op), 71'(lat), (op >= 15) ? 71'd33 : 71'd0);
            check($sformatf("rnd%0d_op%0d_bus", i, op), es2ms_bus, exp_bus(1'b0, rfwe, wa, model(op, a, b), pc));
            check($sformatf("rnd%0d_op%0d_zip", i, op), 71'(es_rf_zip), 71'({1'b0, rfwe, wa, model(op, a, b)}));
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
